// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared func3 codes, responder FSM encoding and width-check helper
package rv_mem_pkg;

    localparam logic [2:0] FUNC3_B  = 3'd0;
    localparam logic [2:0] FUNC3_H  = 3'd1;
    localparam logic [2:0] FUNC3_W  = 3'd2;
    localparam logic [2:0] FUNC3_BU = 3'd4;
    localparam logic [2:0] FUNC3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unsigned widths only make sense for loads; codes 3/6/7 are never legal.
    function automatic logic func3_illegal(input logic [2:0] func3, input logic write);
        logic bad;
        bad = 1'b0;
        case (func3)
            FUNC3_B, FUNC3_H, FUNC3_W: bad = 1'b0;
            FUNC3_BU, FUNC3_HU:        bad = write;
            default:                   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract/extend for loads, lane merge for stores
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  mask;
    logic [31:0] wrep;

    assign byte_sel = rword[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        load_data  = '0;
        mask       = 4'b0000;
        wrep       = wdata;
        misaligned = 1'b0;
        case (func3)
            FUNC3_B, FUNC3_BU: begin
                load_data = {{24{byte_sel[7] & (func3 == FUNC3_B)}}, byte_sel};
                mask      = 4'b0001 << lane;
                wrep      = {4{wdata[7:0]}};
            end
            FUNC3_H, FUNC3_HU: begin
                load_data  = {{16{half_sel[15] & (func3 == FUNC3_H)}}, half_sel};
                mask       = lane[1] ? 4'b1100 : 4'b0011;
                wrep       = {2{wdata[15:0]}};
                misaligned = lane[0];
            end
            FUNC3_W: begin
                load_data  = rword;
                mask       = 4'b1111;
                misaligned = (lane != 2'b00);
            end
            default: ;
        endcase
    end

    // Replicated store data lets each byte pick its lane without a shifter.
    always_comb begin
        store_word = rword;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) store_word[8*i +: 8] = wrep[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - latency-modelled load/store responder over a local word array
module data_mem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state;
    logic [3:0]  cnt;
    logic        write_q;
    logic [2:0]  func3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic [31:0]      rword;
    logic [31:0]      load_data;
    logic [31:0]      store_word;
    logic             misaligned;
    logic             access_err;
    logic             commit;

    assign idx          = addr_q[IDX_W+1:2];
    assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign rword        = out_of_range ? '0 : mem[idx];
    assign access_err   = misaligned | out_of_range | func3_illegal(func3_q, write_q);
    assign commit       = (state == ST_WAIT) && (cnt == 4'd0);
    assign req_ready    = (state == ST_IDLE);

    mem_lane_align u_align (
        .func3      (func3_q),
        .lane       (addr_q[1:0]),
        .rword      (rword),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word),
        .misaligned (misaligned)
    );

    // Storage is not reset; a reset before the commit edge forces IDLE, so the write never fires.
    always_ff @(posedge clk) begin
        if (commit && write_q && !access_err) mem[idx] <= store_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            write_q   <= 1'b0;
            func3_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        func3_q <= req_func3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= access_err;
                        rsp_rdata <= (access_err || write_q) ? 32'd0 : load_data;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
